// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } ifu_state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam int DEF_INS_W       = 32;
  localparam int DEF_INS_ADDRESS = 9;

  // Layout of one buffered fetch at the default widths: instruction above its PC.
  typedef struct packed {
    logic [DEF_INS_W-1:0]       instr;
    logic [DEF_INS_ADDRESS-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} words; flush empties it,
// and a push into a full FIFO is accepted when a pop happens the same cycle.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DATA_W = 41
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int CNT_W = FIFO_PTR_W + 1;

  logic [DATA_W-1:0]     mem_reg [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] rd_ptr_reg;
  logic [FIFO_PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == FIFO_PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, reads the combinational instruction memory and hands words to decode.
// Optional stall/fetch performance counters are built when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                     INS_ADDRESS = 9,
  parameter int                     INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  input  logic                   halt_req,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INS_W-1:0]       if_instr,
  output logic [INS_ADDRESS-1:0] if_pc,
  output logic                   halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            fetch_count
`endif
);

  localparam int ENTRY_W = INS_W + INS_ADDRESS;

  ifu_state_e             state_reg, state_next;
  logic [INS_ADDRESS-1:0] pc_reg, pc_next;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_W-1:0]     fifo_head;
  logic                   pop;
  logic                   fetch;

  assign pop   = !fifo_empty && if_ready;
  // A full buffer still takes a fetch when decode drains it the same cycle.
  assign fetch = (state_reg == RUN) && !redirect_valid && !halt_req && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE:    state_next = RUN;
      RUN:     if (halt_req && !redirect_valid) state_next = HALTED;
      HALTED:  if (redirect_valid) state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (redirect_valid) begin
      state_next = RUN;
      pc_next    = redirect_pc & ~INS_ADDRESS'(3);
    end else if (fetch) begin
      pc_next = pc_reg + INS_ADDRESS'(4);
    end
  end

  ifu_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fetch),
    .pop       (pop),
    .push_data ({imem_rd, pc_reg}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign imem_ra  = pc_reg;
  assign if_valid = !fifo_empty;
  assign if_instr = fifo_empty ? '0 : fifo_head[ENTRY_W-1:INS_ADDRESS];
  assign if_pc    = fifo_empty ? '0 : fifo_head[INS_ADDRESS-1:0];
  assign halted   = (state_reg == HALTED);

`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] fetch_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
      fetch_count_reg  <= '0;
    end else begin
      if ((state_reg == RUN) && fifo_full && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (fetch && (fetch_count_reg != '1))
        fetch_count_reg <= fetch_count_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign fetch_count  = fetch_count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit against a queue-level fetch model.
module tb_instruction_fetch_unit;

  localparam int AW = 9;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_ra;
  logic [IW-1:0] imem_rd;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt_req;
  logic          if_valid;
  logic          if_ready;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   fetch_count;
`endif

  always #5 clk = ~clk;

  logic [IW-1:0] mem [128];
  assign imem_rd = mem[imem_ra[AW-1:2]];

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ra        (imem_ra),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .fetch_count    (fetch_count)
`endif
  );

  typedef struct {
    logic          v;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          h;
    logic [AW-1:0] ra;
  } exp_t;

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  exp_t cyc_q[$];
  ent_t m_q[$];
  int   m_pc;
  bit   m_started;
  bit   m_halted;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: the buffer is a queue of up to two {instr, pc}; decode sees its front.
  function automatic exp_t m_outputs();
    exp_t e;
    e.v     = (m_q.size() > 0);
    e.instr = e.v ? m_q[0].instr : '0;
    e.pc    = e.v ? m_q[0].pc : '0;
    e.h     = m_halted;
    e.ra    = AW'(m_pc);
    return e;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_pc      = 0;
    m_started = 0;
    m_halted  = 0;
  endtask

  // One cycle: drive inputs, queue expected outputs, then advance the model at the edge.
  task automatic step(input bit rv, input int rpc, input bit hr, input bit rdy);
    ent_t en;
    redirect_valid = rv;
    redirect_pc    = AW'(rpc);
    halt_req       = hr;
    if_ready       = rdy;
    cyc_q.push_back(m_outputs());
    @(posedge clk);
    if (rv) begin
      m_q.delete();
      m_pc      = (rpc % 512) / 4 * 4;
      m_started = 1;
      m_halted  = 0;
    end else begin
      if (m_q.size() > 0 && rdy) en = m_q.pop_front();
      if (!m_started) begin
        m_started = 1;
      end else if (!m_halted) begin
        if (hr) begin
          m_halted = 1;
        end else if (m_q.size() < 2) begin
          en.instr = mem[m_pc / 4];
          en.pc    = AW'(m_pc);
          m_q.push_back(en);
          m_pc = (m_pc + 4) % 512;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc_q.delete();
    m_reset();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    if_ready       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_if_valid", if_valid, 0);
    chk("reset_halted", halted, 0);
    chk("reset_imem_ra", imem_ra, 0);
    chk("reset_if_instr", if_instr, 0);
    chk("reset_if_pc", if_pc, 0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("if_valid", if_valid, e.v);
      chk("if_instr", if_instr, e.instr);
      chk("if_pc", if_pc, e.pc);
      chk("halted", halted, e.h);
      chk("imem_ra", imem_ra, e.ra);
      if (if_valid && if_ready)
        $display("xfer t=%0t pc=%03h instr=%08h", $time, if_pc, if_instr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = 32'h00007033;
    mem[1] = 32'h00100093;
    mem[2] = 32'h00200113;
    mem[3] = 32'h00208433;

    // Straight-line fetch with decode always ready.
    do_reset();
    repeat (8) step(0, 0, 0, 1);

    // Decode stalls, buffer fills, then drains with no gap.
    do_reset();
    repeat (2) step(0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1);

    // Redirect to an unaligned target while full and popping.
    repeat (3) step(0, 0, 0, 0);
    step(1, 'h00B, 0, 1);
    repeat (4) step(0, 0, 0, 1);

    // Halt with buffered entries; deasserting halt alone stays halted.
    step(1, 'h000, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    step(1, 'h000, 1, 1);
    repeat (4) step(0, 0, 0, 1);

    // Wrap at the top of the address space.
    step(1, 'h1FC, 0, 1);
    repeat (5) step(0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(15) == 0, int'($urandom_range(511)),
           $urandom_range(7) == 0, $urandom_range(1) == 1);

    // Asynchronous reset while the buffer is full.
    step(1, 'h040, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    chk("pre_reset_valid", if_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_if_valid", if_valid, 0);
    chk("async_imem_ra", imem_ra, 0);
    chk("async_if_pc", if_pc, 0);
    do_reset();
    repeat (8) step(0, 0, 0, 1);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
